// File: rtl/vga_avl_pkg.sv
// Shared types for the VGA text Avalon access arbiter: FSM states, bus widths
// and the command word latched at grant time.
package vga_avl_pkg;

  localparam int AVL_DATA_W     = 32;
  localparam int AVL_BE_W       = 4;
  localparam int AVL_ADDR_MAX_W = 32;
  localparam int LAT_CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD_WAIT,
    ST_COMPLETE
  } arb_state_t;

  // Address field is sized for the widest supported bus; unused upper bits stay 0.
  typedef struct packed {
    logic                      we;
    logic [AVL_ADDR_MAX_W-1:0] addr;
    logic [AVL_BE_W-1:0]       byte_en;
    logic [AVL_DATA_W-1:0]     wdata;
  } avl_cmd_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker
  import vga_avl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // k is the distance from the pointer; the smallest distance with a request wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + k) % NUM_REQ))) begin
          gnt[j] = 1'b1;
          idx    = IDX_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_avl_access_arbiter.sv
// Round-robin Avalon-MM master sharing the VGA text slave among NUM_REQ
// requesters, one outstanding access at a time, grants optionally gated.
module vga_avl_access_arbiter
  import vga_avl_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ-1:0]             REQ_WE,
  input  logic [NUM_REQ*ADDR_W-1:0]      REQ_ADDR,
  input  logic [NUM_REQ*AVL_BE_W-1:0]    REQ_BYTE_EN,
  input  logic [NUM_REQ*AVL_DATA_W-1:0]  REQ_WDATA,
  output logic [NUM_REQ-1:0]             ACK,
  output logic [AVL_DATA_W-1:0]          RDATA,
  input  logic                           GATE_EN,
  output logic                           BUSY,
  output logic                           AVL_CS,
  output logic                           AVL_READ,
  output logic                           AVL_WRITE,
  output logic [AVL_BE_W-1:0]            AVL_BYTE_EN,
  output logic [ADDR_W-1:0]              AVL_ADDR,
  output logic [AVL_DATA_W-1:0]          AVL_WRITEDATA,
  input  logic [AVL_DATA_W-1:0]          AVL_READDATA
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state;
  arb_state_t             state_nxt;
  avl_cmd_t               cmd_q;
  avl_cmd_t               cmd_nxt;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       win_q;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic                   grant_go;
  logic                   cmd_addr_unused;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign grant_go = (state == ST_IDLE) && GATE_EN && (|REQ);

  // Select the winner's command fields out of the packed request buses.
  always_comb begin
    cmd_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        cmd_nxt.we                = REQ_WE[i];
        cmd_nxt.addr[ADDR_W-1:0]  = REQ_ADDR[i*ADDR_W +: ADDR_W];
        cmd_nxt.byte_en           = REQ_BYTE_EN[i*AVL_BE_W +: AVL_BE_W];
        cmd_nxt.wdata             = REQ_WDATA[i*AVL_DATA_W +: AVL_DATA_W];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      win_onehot[j] = (win_q == IDX_W'(j));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (grant_go) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = cmd_q.we ? ST_COMPLETE : ST_RD_WAIT;
      ST_RD_WAIT:  if (cnt_q == '0) state_nxt = ST_COMPLETE;
      ST_COMPLETE: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Every output is a register loaded on the edge that enters the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_q     <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      AVL_CS    <= 1'b0;
      AVL_READ  <= 1'b0;
      AVL_WRITE <= 1'b0;
      ACK       <= '0;
      RDATA     <= '0;
      BUSY      <= 1'b0;
    end else begin
      AVL_CS    <= 1'b0;
      AVL_READ  <= 1'b0;
      AVL_WRITE <= 1'b0;
      ACK       <= '0;
      BUSY      <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            cmd_q     <= cmd_nxt;
            win_q     <= pick_idx;
            AVL_CS    <= 1'b1;
            AVL_WRITE <= cmd_nxt.we;
            AVL_READ  <= ~cmd_nxt.we;
          end
        end
        ST_ISSUE: begin
          if (cmd_q.we) begin
            ACK <= win_onehot;
          end else begin
            cnt_q <= LAT_CNT_W'(READ_LATENCY - 1);
          end
        end
        ST_RD_WAIT: begin
          if (cnt_q == '0) begin
            RDATA <= AVL_READDATA;
            ACK   <= win_onehot;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_COMPLETE: begin
          ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The command latch doubles as the held Avalon address/data/byte-enable registers.
  assign AVL_ADDR        = cmd_q.addr[ADDR_W-1:0];
  assign AVL_BYTE_EN     = cmd_q.byte_en;
  assign AVL_WRITEDATA   = cmd_q.wdata;
  assign cmd_addr_unused = ^cmd_q.addr;

endmodule

// File: tb/tb_vga_avl_access_arbiter.sv
// Bench for vga_avl_access_arbiter: latency-1 and latency-3 instances checked
// every cycle against a transaction-schedule reference model.
module tb_vga_avl_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req [2];
  logic [N-1:0]    req_we [2];
  logic [N*AW-1:0] req_addr [2];
  logic [N*4-1:0]  req_be [2];
  logic [N*32-1:0] req_wdata [2];
  logic [N-1:0]    ack [2];
  logic            gate_en [2];
  logic            busy [2];
  logic            cs [2];
  logic            rd [2];
  logic            wr [2];
  logic [31:0]     rdata [2];
  logic [31:0]     wdata [2];
  logic [31:0]     readdata [2];
  logic [3:0]      be [2];
  logic [AW-1:0]   addr [2];

  vga_avl_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .READ_LATENCY(1)) dut_l1 (
    .CLK(clk), .RESET(rst), .REQ(req[0]), .REQ_WE(req_we[0]), .REQ_ADDR(req_addr[0]),
    .REQ_BYTE_EN(req_be[0]), .REQ_WDATA(req_wdata[0]), .ACK(ack[0]), .RDATA(rdata[0]),
    .GATE_EN(gate_en[0]), .BUSY(busy[0]), .AVL_CS(cs[0]), .AVL_READ(rd[0]),
    .AVL_WRITE(wr[0]), .AVL_BYTE_EN(be[0]), .AVL_ADDR(addr[0]),
    .AVL_WRITEDATA(wdata[0]), .AVL_READDATA(readdata[0]));

  vga_avl_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .READ_LATENCY(3)) dut_l3 (
    .CLK(clk), .RESET(rst), .REQ(req[1]), .REQ_WE(req_we[1]), .REQ_ADDR(req_addr[1]),
    .REQ_BYTE_EN(req_be[1]), .REQ_WDATA(req_wdata[1]), .ACK(ack[1]), .RDATA(rdata[1]),
    .GATE_EN(gate_en[1]), .BUSY(busy[1]), .AVL_CS(cs[1]), .AVL_READ(rd[1]),
    .AVL_WRITE(wr[1]), .AVL_BYTE_EN(be[1]), .AVL_ADDR(addr[1]),
    .AVL_WRITEDATA(wdata[1]), .AVL_READDATA(readdata[1]));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one transaction at a time, scheduled by edge number.
  bit          m_act [2];
  int          m_ack_e [2];
  int          m_done_e [2];
  int          m_win [2];
  int          m_ptr [2];
  logic        m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [3:0]  m_be [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        e_cs [2];
  logic        e_rd [2];
  logic        e_wr [2];
  logic        e_busy [2];
  logic [N-1:0] e_ack [2];

  bit auto_req;
  bit rnd_rdata;
  bit rnd_gate;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cmd(input int d, input int i, input logic we, input logic [AW-1:0] a,
                         input logic [3:0] b, input logic [31:0] w);
    req_we[d][i]              = we;
    req_addr[d][i*AW +: AW]   = a;
    req_be[d][i*4 +: 4]       = b;
    req_wdata[d][i*32 +: 32]  = w;
  endtask

  task automatic rand_cmd(input int d, input int i);
    set_cmd(d, i, 1'($urandom_range(0, 1)), AW'($urandom), 4'($urandom), $urandom);
  endtask

  // Predict what the outputs will be after the coming clock edge.
  task automatic model_edge(input int d);
    int w;
    e_cs[d] = 1'b0; e_rd[d] = 1'b0; e_wr[d] = 1'b0; e_ack[d] = '0;
    if (rst) begin
      m_act[d] = 1'b0; m_ptr[d] = 0; m_we[d] = 1'b0; m_addr[d] = '0;
      m_be[d] = '0; m_wdata[d] = '0; m_rdata[d] = '0; e_busy[d] = 1'b0;
    end else if (m_act[d]) begin
      if (cyc == m_ack_e[d]) begin
        e_ack[d][m_win[d]] = 1'b1;
        if (!m_we[d]) m_rdata[d] = readdata[d];
      end
      if (cyc == m_done_e[d]) begin
        m_act[d]  = 1'b0;
        m_ptr[d]  = (m_win[d] + 1) % N;
        e_busy[d] = 1'b0;
      end else begin
        e_busy[d] = 1'b1;
      end
    end else if (gate_en[d] && (req[d] != '0)) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[d][(m_ptr[d] + k) % N]) w = (m_ptr[d] + k) % N;
      m_win[d]    = w;
      m_we[d]     = req_we[d][w];
      m_addr[d]   = req_addr[d][w*AW +: AW];
      m_be[d]     = req_be[d][w*4 +: 4];
      m_wdata[d]  = req_wdata[d][w*32 +: 32];
      m_act[d]    = 1'b1;
      m_ack_e[d]  = cyc + 1 + (m_we[d] ? 0 : lat(d));
      m_done_e[d] = m_ack_e[d] + 1;
      e_cs[d] = 1'b1; e_wr[d] = m_we[d]; e_rd[d] = !m_we[d]; e_busy[d] = 1'b1;
    end else begin
      e_busy[d] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int d);
    chk($sformatf("L%0d.cs", lat(d)),    32'(cs[d]),    32'(e_cs[d]));
    chk($sformatf("L%0d.rd", lat(d)),    32'(rd[d]),    32'(e_rd[d]));
    chk($sformatf("L%0d.wr", lat(d)),    32'(wr[d]),    32'(e_wr[d]));
    chk($sformatf("L%0d.busy", lat(d)),  32'(busy[d]),  32'(e_busy[d]));
    chk($sformatf("L%0d.ack", lat(d)),   32'(ack[d]),   32'(e_ack[d]));
    chk($sformatf("L%0d.addr", lat(d)),  32'(addr[d]),  32'(m_addr[d]));
    chk($sformatf("L%0d.be", lat(d)),    32'(be[d]),    32'(m_be[d]));
    chk($sformatf("L%0d.wdata", lat(d)), wdata[d],      m_wdata[d]);
    chk($sformatf("L%0d.rdata", lat(d)), rdata[d],      m_rdata[d]);
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (rnd_rdata) readdata[d] = $urandom;
      if (rnd_gate)  gate_en[d]  = ($urandom_range(0, 3) != 0);
      model_edge(d);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) check_outputs(d);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (ack[d][i]) begin
          req[d][i] = 1'b0;
        end else if (auto_req) begin
          if (!req[d][i]) begin
            if ($urandom_range(0, 2) == 0) begin
              rand_cmd(d, i);
              req[d][i] = 1'b1;
            end
          end else if (!(m_act[d] && m_win[d] == i) && $urandom_range(0, 3) == 0) begin
            rand_cmd(d, i);
          end
        end
      end
    end
  endtask

  task automatic drain();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++)
        if (!(m_act[d] && m_win[d] == i)) req[d][i] = 1'b0;
    for (int t = 0; t < 20 && (m_act[0] || m_act[1]); t++) tick();
    chk("drain_busy", {30'd0, busy[1], busy[0]}, 32'd0);
  endtask

  initial begin
    int lat_seen [2];
    logic [N-1:0] ord [4];
    int n_ord;
    int n_hit;
    bit got;
    logic [N-1:0] first;

    rst = 1'b1; auto_req = 1'b0; rnd_rdata = 1'b0; rnd_gate = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; req_we[d] = '0; req_addr[d] = '0; req_be[d] = '0;
      req_wdata[d] = '0; gate_en[d] = 1'b1; readdata[d] = '0;
    end
    repeat (3) tick();
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_ack", 32'(ack[1]), 32'd0);
    rst = 1'b0;
    tick();

    // Single write from requester 0.
    for (int d = 0; d < 2; d++) begin
      set_cmd(d, 0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      req[d][0] = 1'b1;
    end
    tick();
    chk("wr_strobe", 32'(wr[0] & cs[0]), 32'd1);
    chk("wr_addr", 32'(addr[0]), 32'h010);
    chk("wr_data", wdata[0], 32'hDEADBEEF);
    tick();
    chk("wr_ack", 32'(ack[0]), 32'd1);
    chk("wr_strobe_off", 32'(cs[0]), 32'd0);
    chk("wr_rdata", rdata[0], 32'd0);
    tick();

    // Single read from requester 1.
    for (int d = 0; d < 2; d++) begin
      set_cmd(d, 1, 1'b0, 12'h020, 4'hF, 32'h0);
      req[d][1]   = 1'b1;
      readdata[d] = 32'h12345678;
      lat_seen[d] = -1;
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      for (int d = 0; d < 2; d++)
        if (ack[d][1] && lat_seen[d] < 0) begin
          lat_seen[d] = t;
          chk($sformatf("rd_rdata_L%0d", lat(d)), rdata[d], 32'h12345678);
        end
    end
    chk("rd_lat_L1", 32'(lat_seen[0]), 32'd3);
    chk("rd_lat_L3", 32'(lat_seen[1]), 32'd5);

    // Contention: both held, re-raised after each ACK.
    for (int d = 0; d < 2; d++) begin
      set_cmd(d, 0, 1'b1, 12'h100, 4'h1, 32'h1111_0000);
      set_cmd(d, 1, 1'b1, 12'h200, 4'h2, 32'h2222_0000);
      req[d] = 2'b11;
    end
    for (int k = 0; k < 4; k++) ord[k] = '0;
    n_ord = 0;
    for (int t = 0; t < 40 && n_ord < 4; t++) begin
      tick();
      if (ack[0] != '0) begin
        ord[n_ord] = ack[0];
        n_ord++;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          if (!req[d][i] && !ack[d][i]) req[d][i] = 1'b1;
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), 32'(ord[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    drain();

    // Gating.
    for (int d = 0; d < 2; d++) begin
      gate_en[d] = 1'b0;
      set_cmd(d, 0, 1'b1, 12'h155, 4'h3, 32'hA5A5_0F0F);
      req[d][0] = 1'b1;
    end
    n_hit = 0;
    repeat (20) begin
      tick();
      if (cs[0] || busy[0]) n_hit++;
    end
    chk("gate_hold", 32'(n_hit), 32'd0);
    for (int d = 0; d < 2; d++) gate_en[d] = 1'b1;
    tick();
    chk("gate_strobe", 32'(wr[0] & cs[0]), 32'd1);
    for (int d = 0; d < 2; d++) gate_en[d] = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      tick();
      if (ack[0][0]) got = 1'b1;
    end
    chk("gate_ack", 32'(got), 32'd1);
    for (int d = 0; d < 2; d++) gate_en[d] = 1'b1;
    drain();

    // Randomized traffic.
    auto_req = 1'b1; rnd_rdata = 1'b1; rnd_gate = 1'b1;
    repeat (3000) tick();
    auto_req = 1'b0; rnd_gate = 1'b0;
    for (int d = 0; d < 2; d++) gate_en[d] = 1'b1;
    drain();
    rnd_rdata = 1'b0;

    // Reset in the middle of a latency-3 read.
    for (int d = 0; d < 2; d++) begin
      set_cmd(d, 0, 1'b1, 12'h0AA, 4'hF, 32'h0BAD_0001);
      req[d][0] = 1'b1;
    end
    drain();
    for (int t = 0; t < 6; t++) tick();
    for (int d = 0; d < 2; d++) begin
      set_cmd(d, 1, 1'b0, 12'h3C0, 4'hF, 32'h0);
      req[d][1]   = 1'b1;
      readdata[d] = 32'hCAFEF00D;
    end
    repeat (3) tick();
    chk("rst_pre_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) req[d] = '0;
    tick();
    chk("rst_cs", 32'(cs[1] | rd[1] | wr[1]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_addr", 32'(addr[1]), 32'd0);
    chk("rst_rdata", rdata[1], 32'd0);
    rst = 1'b0;
    n_hit = 0;
    repeat (4) begin
      tick();
      if (ack[1] != '0) n_hit++;
    end
    chk("rst_no_ack", 32'(n_hit), 32'd0);
    for (int d = 0; d < 2; d++) begin
      set_cmd(d, 0, 1'b1, 12'h001, 4'hF, 32'h1);
      set_cmd(d, 1, 1'b1, 12'h002, 4'hF, 32'h2);
      req[d] = 2'b11;
    end
    first = '0;
    for (int t = 0; t < 8 && first == '0; t++) begin
      tick();
      if (ack[1] != '0) first = ack[1];
    end
    chk("rst_next_grant", 32'(first), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_avl_access_arbiter.md
Name: vga_avl_access_arbiter

Overview:
- Avalon-MM master that shares the VGA text controller's register/VRAM slave port among NUM_REQ on-chip requesters (e.g. playfield renderer, score/next-piece updater).
- Round-robin arbitration; exactly one outstanding access at a time.
- Optional gating so new accesses start only while GATE_EN is high (e.g. vertical blank).
- Sits between game logic and the VGA text Avalon interface, driving its AVL_* slave pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 12, Avalon word-address width
- READ_LATENCY, 1, cycles from the AVL_READ cycle to valid AVL_READDATA (1..4)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester access request, held until ACK
- REQ_WE  in  NUM_REQ  1 = write, 0 = read
- REQ_ADDR  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- REQ_BYTE_EN  in  NUM_REQ*4  packed byte enables
- REQ_WDATA  in  NUM_REQ*32  packed write data
- ACK  out  NUM_REQ  one-cycle completion pulse, one-hot
- RDATA  out  32  read data, valid in the ACK cycle of a read
- GATE_EN  in  1  new grants allowed only while high
- BUSY  out  1  high whenever FSM is not IDLE
- AVL_CS  out  1  slave chip select
- AVL_READ  out  1  read strobe
- AVL_WRITE  out  1  write strobe
- AVL_BYTE_EN  out  4  byte enables
- AVL_ADDR  out  ADDR_W  address
- AVL_WRITEDATA  out  32  write data
- AVL_READDATA  in  32  read data from slave

Behaviour:
- Reset:
  - All outputs 0, FSM = IDLE, round-robin pointer = 0, latency counter = 0.
  - RESET mid-access aborts immediately: strobes drop the next cycle and no ACK is issued.
- States: IDLE, ISSUE, RD_WAIT, COMPLETE.
- IDLE:
  - If GATE_EN=1 and any REQ bit is set, grant the first set bit searching from pointer upward, modulo NUM_REQ.
  - Latch winner index, WE, address, byte enables and wdata into command registers, then go to ISSUE.
  - If GATE_EN=0 or no request, stay in IDLE.
- ISSUE (exactly one cycle):
  - AVL_CS=1, plus AVL_WRITE=WE or AVL_READ=~WE; AVL_ADDR, AVL_BYTE_EN and AVL_WRITEDATA come from the latched command.
  - Write: go to COMPLETE.
  - Read: load counter = READ_LATENCY-1, then go to RD_WAIT.
- RD_WAIT:
  - When counter = 0, capture AVL_READDATA into RDATA and go to COMPLETE; otherwise decrement.
  - AVL_CS, AVL_READ and AVL_WRITE are 0 throughout.
- COMPLETE:
  - ACK[winner]=1 for one cycle; pointer := winner+1 (wrapping to 0 at NUM_REQ); go to IDLE.
- Latency:
  - Write: request seen in cycle 0, strobe in cycle 1, ACK in cycle 2.
  - Read: ACK in cycle 2+READ_LATENCY.
  - Back-to-back minimum spacing is 3 cycles for writes.
- Requester rules:
  - Hold REQ and the command stable from assertion until ACK is seen.
  - Drop REQ by the cycle after ACK, or it is treated as a new request.
  - Command changes while REQ is high but not yet granted are allowed; the value is sampled at grant.
- GATE_EN affects only the IDLE grant decision; an in-flight access always completes.
- AVL_BYTE_EN, AVL_ADDR and AVL_WRITEDATA hold their last values outside ISSUE; AVL_CS/AVL_READ/AVL_WRITE are 0 outside ISSUE.
- RDATA holds its last read value until the next read completes; writes do not change it.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 grants.
- All outputs are registered.

Decomposition:
- Shared package vga_avl_pkg holds:
  - the FSM state enum (arb_state_t);
  - AVL_DATA_W = 32 and AVL_BE_W = 4;
  - a packed command struct (we, addr, byte_en, wdata) used for the latch.
- One natural sub-module: rr_priority_picker, combinational. Inputs are the request vector and pointer; outputs are a one-hot grant and the encoded index.

Test Plan:
- Reset then a single write: REQ[0]=1, WE=1, ADDR=0x010, BE=0xF, WDATA=0xDEADBEEF. Required: AVL_WRITE/AVL_CS high for exactly 1 cycle with those values, ACK[0] pulses 2 cycles after the request, RDATA stays 0.
- Single read with READ_LATENCY=1: REQ[1]=1, ADDR=0x020, slave returns 0x12345678. Required: AVL_READ for 1 cycle, ACK[1] and RDATA=0x12345678 three cycles after the request.
- Contention: REQ=2'b11 held continuously, releasing each after its ACK and re-raising it. Required grant order 0,1,0,1; no double grants.
- Gating: GATE_EN=0 with REQ[0]=1 for 20 cycles gives no strobe and BUSY=0. Raising GATE_EN gives a write strobe the next cycle. Dropping GATE_EN during ISSUE still lets ACK arrive.
- Reset mid-read (READ_LATENCY=3): assert RESET during RD_WAIT. Required: no ACK, all outputs 0 the following cycle, and the next grant goes to requester 0.
